segvect_ctrl: RTL and testbench
===============================

// Module: segvect_ctrl
// PURPOSE
//  Access controller for the segmented rule-vector memory (segvectmemx) of the TCAM. Shares the single
//  memory port between a search requester and a rule-update requester. After reset, sweeps all entries to zero,
//  then pipelines searches and returns the rule vector plus a hit flag per key.
// PARAMETERS
//  KWID    104            search/update key width
//  DWID    8              data bits per segment; also per-segment address width (DEP = 2**DWID = 256)
//  SEGWID  DWID+2         segment width: data + 2 status bits; bit DWID of each segment = entry-valid
//  NSEG    KWID/DWID      segments per key (13)
//  VTWID   SEGWID*NSEG    rule-vector width (130)
//  TWID    4              search tag width
//  RDLAT   1              memory read latency, mem_ra to mem_rdo, in cycles
//  STARVE  4              max consecutive search grants while an update waits
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  srch_valid in   1      search request
//  srch_ready out  1      search accepted when valid&ready
//  srch_key   in   KWID   search key
//  srch_tag   in   TWID   requester tag, returned with result
//  res_valid  out  1      one-cycle result strobe; no backpressure
//  res_tag    out  TWID   tag of returned search
//  res_vec    out  VTWID  rule vector read for the key
//  res_hit    out  1      AND over all NSEG segments of bit DWID
//  upd_valid  in   1      rule-update request
//  upd_ready  out  1      update accepted when valid&ready
//  upd_key    in   KWID   key/address to write
//  upd_vec    in   VTWID  rule vector to write
//  init_done  out  1      high once the clear sweep completes
//  mem_ra     out  KWID   memory read address (registered)
//  mem_wa     out  KWID   memory write address (registered)
//  mem_wdi    out  VTWID  memory write data (registered)
//  mem_we     out  1      memory write enable (registered)
//  mem_rdo    in   VTWID  memory read data
// BEHAVIOUR
//  Reset: state<=INIT, init_cnt<=0; all outputs 0 (incl. init_done, readies, res_*, mem_*); pipeline flushed.
//  INIT: each cycle mem_we=1, mem_wa={NSEG{init_cnt}}, mem_wdi=0; init_cnt counts 0..DEP-1. After the
//   DEP-th write (256 cycles), state->RUN, init_done=1 the following cycle; readies stay 0 throughout INIT.
//  RUN, arbitration (combinational readies, at most one grant per cycle):
//   srch_ready = RUN & (!upd_valid | starve_cnt<STARVE); upd_ready = RUN & (!srch_valid | starve_cnt>=STARVE).
//   starve_cnt++ (sat. at STARVE) on search grant while upd_valid=1; cleared on update grant or upd_valid=0.
//  Search fired at edge T: mem_ra=srch_key, mem_we=0 in cycle T+1; mem_rdo sampled at T+1+RDLAT; res_valid,
//   res_vec, res_hit, res_tag registered and high in cycle T+2+RDLAT (T+3 at RDLAT=1). Fully pipelined:
//   one search/cycle sustained; tag/valid carried in an RDLAT+2 deep shift register.
//  Update fired at edge T: mem_we=1, mem_wa=upd_key, mem_wdi=upd_vec for exactly cycle T+1; else mem_we=0.
//  Ordering: the memory commits a write on the edge ending its cycle, so a search granted after an update
//   returns the new vector; no bubble inserted. Update and search never both granted in one cycle.
//  Idle cycle: mem_we=0; mem_ra holds last value; res_valid=0.
//  Reset mid-operation: in-flight searches dropped (no res_valid), pending update discarded, INIT re-run.
//  Arithmetic: init_cnt DWID bits, no wrap used (terminal count DEP-1); starve_cnt clog2(STARVE+1) bits.
// STRUCTURE
//  segvect_pkg: KWID/DWID/SEGWID/NSEG/VTWID constants, state enum {INIT, RUN}, seg_valid bit index.
//  Sub-module segvect_arb: search/update priority arbiter with starvation counter (readies + grant).
//  Top: INIT sweep FSM, registered mem drive, result pipeline and hit reduction.
// TESTING
//  1 rst 2 cycles -> all outputs 0; 256 writes with mem_wa=13x{00..FF}, mem_wdi=0; init_done high at cycle 257.
//  2 upd key 0x405B6A00A468_0000FFFFFFFFFF, vec 13x{0x100}; search same key, tag 3 -> at T+3 res_vec=13x{0x100},
//    res_hit=1, res_tag=3.
//  3 search unwritten key 0xC0970B00..FF, no update -> res_vec=0, res_hit=0; vec 13x{0x0FF} written -> res_hit=0.
//  4 srch_valid and upd_valid held high, STARVE=4 -> grant pattern S,S,S,S,U repeating; no update lost.
//  5 10 back-to-back searches (tags 0..9) -> 10 consecutive res_valid cycles, tags in order, no gaps.
//  6 rst asserted with 2 searches in flight -> no res_valid afterwards; INIT restarts from address 0.

Source files
------------

// File: rtl/segvect_pkg.sv
// segvect_pkg: shared sizes, FSM states and helpers for the
// segmented rule-vector memory controller.
package segvect_pkg;

    localparam int KWID    = 104;
    localparam int DWID    = 8;
    localparam int SEGWID  = DWID + 2;
    localparam int NSEG    = KWID / DWID;
    localparam int VTWID   = SEGWID * NSEG;
    localparam int TWID    = 4;
    localparam int RDLAT   = 1;
    localparam int STARVE  = 4;
    localparam int DEP     = 1 << DWID;
    localparam int SEG_VLD = DWID;
    localparam int SCWID   = $clog2(STARVE + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic            vld;
        logic [TWID-1:0] tag;
    } tag_slot_t;

    function automatic logic vec_hit(input logic [VTWID-1:0] v);
        logic h;
        h = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            h = h & v[i*SEGWID+SEG_VLD];
        end
        return h;
    endfunction

endpackage

// File: rtl/segvect_ctrl_if.sv
// segvect_ctrl_if: search, update, result and memory-port bundle
// between the requesters/memory and the controller.
interface segvect_ctrl_if;
    import segvect_pkg::*;

    logic             srch_valid;
    logic             srch_ready;
    logic [KWID-1:0]  srch_key;
    logic [TWID-1:0]  srch_tag;
    logic             res_valid;
    logic [TWID-1:0]  res_tag;
    logic [VTWID-1:0] res_vec;
    logic             res_hit;
    logic             upd_valid;
    logic             upd_ready;
    logic [KWID-1:0]  upd_key;
    logic [VTWID-1:0] upd_vec;
    logic             init_done;
    logic [KWID-1:0]  mem_ra;
    logic [KWID-1:0]  mem_wa;
    logic [VTWID-1:0] mem_wdi;
    logic             mem_we;
    logic [VTWID-1:0] mem_rdo;

    modport slave (
        input  srch_valid, srch_key, srch_tag,
        input  upd_valid, upd_key, upd_vec, mem_rdo,
        output srch_ready, upd_ready, init_done,
        output res_valid, res_tag, res_vec, res_hit,
        output mem_ra, mem_wa, mem_wdi, mem_we
    );

    modport master (
        output srch_valid, srch_key, srch_tag,
        output upd_valid, upd_key, upd_vec, mem_rdo,
        input  srch_ready, upd_ready, init_done,
        input  res_valid, res_tag, res_vec, res_hit,
        input  mem_ra, mem_wa, mem_wdi, mem_we
    );

endinterface

// File: rtl/segvect_arb.sv
// segvect_arb: search-first arbiter that yields to a waiting update
// after STARVE consecutive search grants.
module segvect_arb
    import segvect_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic srch_valid_i,
    input  logic upd_valid_i,
    output logic srch_ready_o,
    output logic upd_ready_o,
    output logic srch_gnt_o,
    output logic upd_gnt_o
);

    logic [SCWID-1:0] starve_q, starve_d;
    logic             starved;

    always_comb begin
        starved      = (starve_q >= SCWID'(STARVE));
        srch_ready_o = run_i & (~upd_valid_i | ~starved);
        upd_ready_o  = run_i & (~srch_valid_i | starved);
        srch_gnt_o   = srch_valid_i & srch_ready_o;
        upd_gnt_o    = upd_valid_i & upd_ready_o;
        starve_d     = starve_q;
        if (upd_gnt_o || !upd_valid_i) begin
            starve_d = '0;
        end else if (srch_gnt_o && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/segvect_ctrl.sv
// segvect_ctrl: clears every memory entry after reset, then serves
// pipelined searches and single-cycle rule updates on one port.
module segvect_ctrl
    import segvect_pkg::*;
(
    input logic           clk,
    input logic           rst,
    segvect_ctrl_if.slave bus
);

    logic [0:0]          state_q, state_d;
    logic [DWID-1:0]     init_cnt_q, init_cnt_d;
    logic                init_done_q;
    logic                srch_rdy, upd_rdy;
    logic                srch_gnt, upd_gnt;
    logic                mem_we_q, mem_we_d;
    logic [KWID-1:0]     mem_ra_q, mem_ra_d;
    logic [KWID-1:0]     mem_wa_q, mem_wa_d;
    logic [VTWID-1:0]    mem_wdi_q, mem_wdi_d;
    tag_slot_t [RDLAT:0] pipe_q;
    tag_slot_t           res_q;
    logic [VTWID-1:0]    res_vec_q;
    logic                res_hit_q;

    segvect_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .run_i        (init_done_q),
        .srch_valid_i (bus.srch_valid),
        .upd_valid_i  (bus.upd_valid),
        .srch_ready_o (srch_rdy),
        .upd_ready_o  (upd_rdy),
        .srch_gnt_o   (srch_gnt),
        .upd_gnt_o    (upd_gnt)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we_d   = 1'b0;
        mem_ra_d   = mem_ra_q;
        mem_wa_d   = mem_wa_q;
        mem_wdi_d  = mem_wdi_q;
        unique case (state_q)
            ST_INIT: begin
                // same index in every segment clears one row per cycle
                mem_we_d   = 1'b1;
                mem_wa_d   = {NSEG{init_cnt_q}};
                mem_wdi_d  = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == DWID'(DEP - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_gnt) begin
                    mem_we_d  = 1'b1;
                    mem_wa_d  = bus.upd_key;
                    mem_wdi_d = bus.upd_vec;
                end
                if (srch_gnt) begin
                    mem_ra_d = bus.srch_key;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_ra_q    <= '0;
            mem_wa_q    <= '0;
            mem_wdi_q   <= '0;
            pipe_q      <= '0;
            res_q       <= '0;
            res_vec_q   <= '0;
            res_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_q == ST_RUN);
            mem_we_q    <= mem_we_d;
            mem_ra_q    <= mem_ra_d;
            mem_wa_q    <= mem_wa_d;
            mem_wdi_q   <= mem_wdi_d;
            pipe_q      <= {pipe_q[RDLAT-1:0],
                            tag_slot_t'{vld: srch_gnt,
                                        tag: bus.srch_tag}};
            res_q       <= pipe_q[RDLAT].vld ? pipe_q[RDLAT] : '0;
            res_vec_q   <= pipe_q[RDLAT].vld ? bus.mem_rdo : '0;
            res_hit_q   <= pipe_q[RDLAT].vld & vec_hit(bus.mem_rdo);
        end
    end

    assign bus.srch_ready = srch_rdy;
    assign bus.upd_ready  = upd_rdy;
    assign bus.init_done  = init_done_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_ra     = mem_ra_q;
    assign bus.mem_wa     = mem_wa_q;
    assign bus.mem_wdi    = mem_wdi_q;
    assign bus.res_valid  = res_q.vld;
    assign bus.res_tag    = res_q.tag;
    assign bus.res_vec    = res_vec_q;
    assign bus.res_hit    = res_hit_q;

endmodule

// File: tb/tb_segvect_ctrl.sv
// tb_segvect_ctrl: segmented memory environment plus a transaction-level
// model checked every cycle, with directed scenarios and literal pins.
module tb_segvect_ctrl;
    import segvect_pkg::*;

    typedef struct {
        int               due;
        logic [TWID-1:0]  tag;
        logic [VTWID-1:0] vec;
    } exp_t;

    typedef struct {
        int               cyc;
        logic [TWID-1:0]  tag;
        logic [VTWID-1:0] vec;
        logic             hit;
    } obs_t;

    localparam logic [KWID-1:0] K2 = 104'h405B6A00A468_0000FFFFFFFFFF;
    localparam logic [KWID-1:0] K3 = 104'hC0970B11_22334455_66778899_AA;
    localparam logic [VTWID-1:0] V2 = {NSEG{10'h100}};
    localparam logic [VTWID-1:0] V3 = {NSEG{10'h0FF}};
    localparam logic [VTWID-1:0] V4 = {NSEG{10'h155}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    segvect_ctrl_if bus ();

    segvect_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [SEGWID-1:0] mem [NSEG][DEP];
    logic [SEGWID-1:0] mdl [NSEG][DEP];

    initial begin
        for (int i = 0; i < NSEG; i++)
            for (int j = 0; j < DEP; j++)
                mem[i][j] = 10'h3FF;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NSEG; i++) begin
            bus.mem_rdo[i*SEGWID +: SEGWID] <=
                mem[i][bus.mem_ra[i*DWID +: DWID]];
            if (bus.mem_we)
                mem[i][bus.mem_wa[i*DWID +: DWID]] <=
                    bus.mem_wdi[i*SEGWID +: SEGWID];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rst_e = 1'b0;
    bit armed = 1'b0;
    int init_k = 0;
    int scnt = 0;
    logic exp_we = 1'b0;
    logic [KWID-1:0] exp_ra = '0;
    logic [KWID-1:0] exp_wa = '0;
    logic [VTWID-1:0] exp_wdi = '0;
    exp_t rq[$];
    obs_t rlog[$];
    int glog[$];
    bit glog_en = 1'b0;

    task automatic chk(input string nm, input logic [VTWID-1:0] got,
                       input logic [VTWID-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [VTWID-1:0] mread(input logic [KWID-1:0] k);
        logic [VTWID-1:0] v;
        for (int i = 0; i < NSEG; i++)
            v[i*SEGWID +: SEGWID] = mdl[i][k[i*DWID +: DWID]];
        return v;
    endfunction

    function automatic logic hitof(input logic [VTWID-1:0] v);
        for (int i = 0; i < NSEG; i++)
            if (!v[i*SEGWID+DWID]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_e = rst;
    end

    always @(negedge clk) begin
        logic esr, eur, sf, uf;
        logic [DWID-1:0] a;
        if (rst_e) begin
            armed = 1'b1;
            chk("rst_we", VTWID'(bus.mem_we), '0);
            chk("rst_ra", VTWID'(bus.mem_ra), '0);
            chk("rst_wa", VTWID'(bus.mem_wa), '0);
            chk("rst_wdi", bus.mem_wdi, '0);
            chk("rst_done", VTWID'(bus.init_done), '0);
            chk("rst_rv", VTWID'(bus.res_valid), '0);
            chk("rst_rvec", bus.res_vec, '0);
            chk("rst_rhit", VTWID'(bus.res_hit), '0);
            chk("rst_rtag", VTWID'(bus.res_tag), '0);
            chk("rst_srdy", VTWID'(bus.srch_ready), '0);
            chk("rst_urdy", VTWID'(bus.upd_ready), '0);
            rq.delete();
            init_k = 0;
            scnt = 0;
            exp_ra = '0;
            exp_we = 1'b0;
            for (int i = 0; i < NSEG; i++)
                for (int j = 0; j < DEP; j++)
                    mdl[i][j] = '0;
        end else if (armed && init_k < DEP) begin
            a = init_k[DWID-1:0];
            chk("init_we", VTWID'(bus.mem_we), VTWID'(1));
            chk("init_wa", VTWID'(bus.mem_wa), VTWID'({NSEG{a}}));
            chk("init_wdi", bus.mem_wdi, '0);
            chk("init_done", VTWID'(bus.init_done), '0);
            chk("init_srdy", VTWID'(bus.srch_ready), '0);
            chk("init_urdy", VTWID'(bus.upd_ready), '0);
            chk("init_rv", VTWID'(bus.res_valid), '0);
            chk("init_ra", VTWID'(bus.mem_ra), VTWID'(exp_ra));
            init_k++;
        end else if (armed) begin
            chk("done", VTWID'(bus.init_done), VTWID'(1));
            chk("we", VTWID'(bus.mem_we), VTWID'(exp_we));
            if (exp_we) begin
                chk("wa", VTWID'(bus.mem_wa), VTWID'(exp_wa));
                chk("wdi", bus.mem_wdi, exp_wdi);
            end
            chk("ra", VTWID'(bus.mem_ra), VTWID'(exp_ra));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("res_valid", VTWID'(bus.res_valid), VTWID'(1));
                chk("res_tag", VTWID'(bus.res_tag), VTWID'(rq[0].tag));
                chk("res_vec", bus.res_vec, rq[0].vec);
                chk("res_hit", VTWID'(bus.res_hit),
                    VTWID'(hitof(rq[0].vec)));
                void'(rq.pop_front());
            end else begin
                chk("res_idle", VTWID'(bus.res_valid), '0);
            end
            esr = !bus.upd_valid || scnt < STARVE;
            eur = !bus.srch_valid || scnt >= STARVE;
            chk("srch_ready", VTWID'(bus.srch_ready), VTWID'(esr));
            chk("upd_ready", VTWID'(bus.upd_ready), VTWID'(eur));
            sf = bus.srch_valid && esr;
            uf = bus.upd_valid && eur;
            if (glog_en)
                glog.push_back((bus.srch_valid && bus.srch_ready) ? 1 :
                               (bus.upd_valid && bus.upd_ready) ? 2 : 0);
            exp_we = uf;
            if (uf) begin
                exp_wa = bus.upd_key;
                exp_wdi = bus.upd_vec;
                for (int i = 0; i < NSEG; i++)
                    mdl[i][bus.upd_key[i*DWID +: DWID]] =
                        bus.upd_vec[i*SEGWID +: SEGWID];
            end
            if (sf) begin
                exp_ra = bus.srch_key;
                rq.push_back('{cyc + 3, bus.srch_tag, mread(bus.srch_key)});
            end
            if (uf || !bus.upd_valid) scnt = 0;
            else if (sf && scnt < STARVE) scnt = scnt + 1;
        end
        if (bus.res_valid)
            rlog.push_back('{cyc, bus.res_tag, bus.res_vec, bus.res_hit});
    end

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s got=no_handshake want=handshake", nm);
    endtask

    task automatic send_s(input logic [KWID-1:0] k,
                          input logic [TWID-1:0] t);
        bit ok;
        int n;
        bus.srch_valid = 1'b1;
        bus.srch_key = k;
        bus.srch_tag = t;
        ok = 1'b0;
        n = 0;
        while (!ok) begin
            @(negedge clk);
            ok = bus.srch_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n >= 20) begin
                timeout("srch_wait");
                ok = 1'b1;
            end
        end
        bus.srch_valid = 1'b0;
    endtask

    task automatic send_u(input logic [KWID-1:0] k,
                          input logic [VTWID-1:0] v);
        bit ok;
        int n;
        bus.upd_valid = 1'b1;
        bus.upd_key = k;
        bus.upd_vec = v;
        ok = 1'b0;
        n = 0;
        while (!ok) begin
            @(negedge clk);
            ok = bus.upd_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n >= 20) begin
                timeout("upd_wait");
                ok = 1'b1;
            end
        end
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.init_done && n < 400);
        chk(nm, VTWID'(n), VTWID'(257));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_one(input string nm, input logic [TWID-1:0] t,
                           input logic [VTWID-1:0] v, input logic h);
        chk({nm, "_cnt"}, VTWID'(rlog.size()), VTWID'(1));
        if (rlog.size() == 1) begin
            chk({nm, "_tag"}, VTWID'(rlog[0].tag), VTWID'(t));
            chk({nm, "_vec"}, rlog[0].vec, v);
            chk({nm, "_hit"}, VTWID'(rlog[0].hit), VTWID'(h));
        end
    endtask

    initial begin
        bus.srch_valid = 1'b0;
        bus.srch_key = '0;
        bus.srch_tag = '0;
        bus.upd_valid = 1'b0;
        bus.upd_key = '0;
        bus.upd_vec = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_init("init_lat");
        idle(2);

        rlog.delete();
        send_u(K2, V2);
        send_s(K2, 4'd3);
        idle(6);
        chk_one("t2", 4'd3, V2, 1'b1);

        rlog.delete();
        send_s(K3, 4'd4);
        idle(6);
        chk_one("t3a", 4'd4, '0, 1'b0);
        rlog.delete();
        send_u(K3, V3);
        send_s(K3, 4'd5);
        idle(6);
        chk_one("t3b", 4'd5, V3, 1'b0);

        glog.delete();
        bus.srch_valid = 1'b1;
        bus.srch_key = K2;
        bus.srch_tag = 4'd6;
        bus.upd_valid = 1'b1;
        bus.upd_key = K3;
        bus.upd_vec = V4;
        glog_en = 1'b1;
        idle(15);
        glog_en = 1'b0;
        bus.srch_valid = 1'b0;
        bus.upd_valid = 1'b0;
        chk("t4_len", VTWID'(glog.size()), VTWID'(15));
        for (int i = 0; i < 15 && i < glog.size(); i++)
            chk($sformatf("t4_gnt%0d", i), VTWID'(glog[i]),
                VTWID'((i % 5 == 4) ? 2 : 1));
        idle(6);

        rlog.delete();
        for (int i = 0; i < 10; i++)
            send_s((i % 2 == 0) ? K2 : K3, TWID'(i));
        idle(6);
        chk("t5_cnt", VTWID'(rlog.size()), VTWID'(10));
        for (int i = 0; i < 10 && i < rlog.size(); i++) begin
            chk($sformatf("t5_tag%0d", i), VTWID'(rlog[i].tag), VTWID'(i));
            chk($sformatf("t5_gap%0d", i), VTWID'(rlog[i].cyc - rlog[0].cyc),
                VTWID'(i));
        end

        rlog.delete();
        send_s(K2, 4'd1);
        send_s(K3, 4'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init("reinit_lat");
        chk("t6_dropped", VTWID'(rlog.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
